// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [2:0] {
    RST  = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    FULL = 3'd3,
    DROP = 3'd4
  } fetch_state_e;

  localparam int unsigned INST_BYTES       = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, one-outstanding-request fetch FSM and
// instruction holding register, with core redirect taking priority.
//
// state | meaning
// RST   | in or just out of reset, nothing requested
// REQ   | request presented at pc, waiting for memory to accept
// WAIT  | request accepted, waiting for the response
// FULL  | instruction held for decode until consumed or redirected
// DROP  | redirect left a stale response in flight; discard it
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  inst_q, inst_d;
  logic [31:0]  inst_pc_q, inst_pc_d;
  logic         req_valid_q;
  logic         inst_valid_q;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;

    unique case (state_q)
      RST: state_d = REQ;

      REQ: begin
        if (redirect) begin
          pc_d    = align_pc(redirect_pc);
          state_d = imem_req_ready ? DROP : REQ;
        end else if (imem_req_ready) begin
          state_d = WAIT;
        end
      end

      WAIT: begin
        if (redirect) begin
          pc_d    = align_pc(redirect_pc);
          state_d = imem_resp_valid ? REQ : DROP;
        end else if (imem_resp_valid) begin
          inst_d    = imem_resp_data;
          inst_pc_d = pc_q;
          state_d   = FULL;
        end
      end

      FULL: begin
        if (redirect) begin
          pc_d    = align_pc(redirect_pc);
          state_d = REQ;
        end else if (inst_ready) begin
          pc_d    = pc_q + 32'(INST_BYTES);
          state_d = REQ;
        end
      end

      DROP: begin
        // A redirect here only retargets; the stale response is still owed.
        if (redirect) pc_d = align_pc(redirect_pc);
        if (imem_resp_valid) state_d = REQ;
      end

      default: state_d = RST;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= RST;
      pc_q         <= RESET_PC;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      req_valid_q  <= 1'b0;
      inst_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      req_valid_q  <= (state_d == REQ);
      inst_valid_q <= (state_d == FULL);
    end
  end

  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = pc_q;
  assign inst_valid     = inst_valid_q;
  assign inst           = inst_q;
  assign inst_pc        = inst_pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with hand-computed expectations.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        redirect;
  logic [31:0] redirect_pc;

  int n_cmp = 0;
  int n_err = 0;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .inst_valid      (inst_valid),
    .inst            (inst),
    .inst_pc         (inst_pc),
    .inst_ready      (inst_ready),
    .redirect        (redirect),
    .redirect_pc     (redirect_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge; outputs now reflect that edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n         = 1'b0;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    inst_ready      = 1'b0;
    redirect        = 1'b0;
    redirect_pc     = '0;

    // Reset values
    tick(); tick();
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_req_addr", imem_req_addr, 32'h0);
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);
    reset_n = 1'b1;

    // Zero-wait fetch at 0x0
    tick();
    chk("first_req_valid", 32'(imem_req_valid), 32'd1);
    chk("first_req_addr", imem_req_addr, 32'h0);
    imem_req_ready = 1'b1;
    tick();
    chk("wait_req_valid", 32'(imem_req_valid), 32'd0);
    chk("wait_inst_valid", 32'(inst_valid), 32'd0);
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h2008_0005;
    tick();
    chk("zw_inst_valid", 32'(inst_valid), 32'd1);
    chk("zw_inst", inst, 32'h2008_0005);
    chk("zw_inst_pc", inst_pc, 32'h0);
    chk("zw_full_req_valid", 32'(imem_req_valid), 32'd0);
    imem_resp_valid = 1'b0;
    inst_ready      = 1'b1;
    tick();
    chk("zw_next_req_valid", 32'(imem_req_valid), 32'd1);
    chk("zw_next_req_addr", imem_req_addr, 32'h4);
    chk("zw_consumed_valid", 32'(inst_valid), 32'd0);

    // Backpressure at pc 0x4; spurious responses in FULL are ignored
    inst_ready     = 1'b0;
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hAAAA_0001;
    tick();
    imem_resp_data = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      chk("bp_inst_valid", 32'(inst_valid), 32'd1);
      chk("bp_inst", inst, 32'hAAAA_0001);
      chk("bp_inst_pc", inst_pc, 32'h4);
      chk("bp_req_valid", 32'(imem_req_valid), 32'd0);
      tick();
    end
    imem_resp_valid = 1'b0;
    inst_ready      = 1'b1;
    tick();
    chk("bp_next_req_valid", 32'(imem_req_valid), 32'd1);
    chk("bp_next_req_addr", imem_req_addr, 32'h8);
    inst_ready = 1'b0;

    // Memory stall at pc 0x8
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_req_valid", 32'(imem_req_valid), 32'd1);
      chk("stall_req_addr", imem_req_addr, 32'h8);
    end
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("stall_wait_req_valid", 32'(imem_req_valid), 32'd0);
      chk("stall_wait_inst_valid", 32'(inst_valid), 32'd0);
      tick();
    end
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h1111_2222;
    tick();
    chk("stall_inst", inst, 32'h1111_2222);
    chk("stall_inst_pc", inst_pc, 32'h8);
    imem_resp_data = 32'h3333_3333;
    tick();
    chk("stall_single_capture", inst, 32'h1111_2222);
    chk("stall_no_dup_req", 32'(imem_req_valid), 32'd0);
    imem_resp_valid = 1'b0;
    inst_ready      = 1'b1;
    tick();
    chk("stall_next_addr", imem_req_addr, 32'hC);
    inst_ready = 1'b0;

    // Redirect in WAIT -> DROP, stale response discarded
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    redirect       = 1'b1;
    redirect_pc    = 32'h0000_0103;
    tick();
    redirect = 1'b0;
    chk("drop_req_valid", 32'(imem_req_valid), 32'd0);
    chk("drop_pc", imem_req_addr, 32'h100);
    tick();
    chk("drop_hold_req_valid", 32'(imem_req_valid), 32'd0);
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hBAD0_BAD0;
    tick();
    imem_resp_valid = 1'b0;
    chk("drop_discard_valid", 32'(inst_valid), 32'd0);
    chk("drop_req_valid_after", 32'(imem_req_valid), 32'd1);
    chk("drop_req_addr_after", imem_req_addr, 32'h100);

    // Redirect in REQ without accept -> REQ at new pc next cycle
    redirect    = 1'b1;
    redirect_pc = 32'h40;
    tick();
    redirect = 1'b0;
    chk("req_redir_valid", 32'(imem_req_valid), 32'd1);
    chk("req_redir_addr", imem_req_addr, 32'h40);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h4040_4040;
    tick();
    imem_resp_valid = 1'b0;
    chk("full40_inst_pc", inst_pc, 32'h40);

    // Redirect coincident with consume in FULL wins over pc+4
    redirect    = 1'b1;
    redirect_pc = 32'h80;
    inst_ready  = 1'b1;
    tick();
    redirect   = 1'b0;
    inst_ready = 1'b0;
    chk("full_redir_addr", imem_req_addr, 32'h80);
    chk("full_redir_inst_valid", 32'(inst_valid), 32'd0);

    // Wrap: pc 0xFFFF_FFFC consumed -> 0x0 (low bits of redirect_pc forced 0)
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFE;
    tick();
    redirect = 1'b0;
    chk("wrap_redir_addr", imem_req_addr, 32'hFFFF_FFFC);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h0000_0005;
    tick();
    imem_resp_valid = 1'b0;
    chk("wrap_inst_pc", inst_pc, 32'hFFFF_FFFC);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    chk("wrap_next_addr", imem_req_addr, 32'h0);
    chk("wrap_next_valid", 32'(imem_req_valid), 32'd1);

    // Redirect in REQ with accept -> DROP
    redirect       = 1'b1;
    redirect_pc    = 32'h200;
    imem_req_ready = 1'b1;
    tick();
    redirect       = 1'b0;
    imem_req_ready = 1'b0;
    chk("reqacc_redir_valid", 32'(imem_req_valid), 32'd0);
    chk("reqacc_redir_addr", imem_req_addr, 32'h200);
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h0BAD_0BAD;
    tick();
    imem_resp_valid = 1'b0;
    chk("reqacc_discard_valid", 32'(inst_valid), 32'd0);
    chk("reqacc_req_addr", imem_req_addr, 32'h200);
    chk("reqacc_req_valid", 32'(imem_req_valid), 32'd1);

    // Reset asserted in WAIT, late response after release is ignored
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("async_rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("async_rst_addr", imem_req_addr, 32'h0);
    chk("async_rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("async_rst_inst", inst, 32'h0);
    tick();
    reset_n         = 1'b1;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h7777_7777;
    tick();
    imem_resp_valid = 1'b0;
    chk("rerst_req_valid", 32'(imem_req_valid), 32'd1);
    chk("rerst_req_addr", imem_req_addr, 32'h0);
    chk("rerst_inst_valid", 32'(inst_valid), 32'd0);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h0000_0009;
    tick();
    imem_resp_valid = 1'b0;
    chk("rerst_inst", inst, 32'h0000_0009);
    chk("rerst_inst_pc", inst_pc, 32'h0);
    chk("rerst_inst_valid_full", 32'(inst_valid), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
